regfile_seq: RTL
================

// Module: regfile_seq
// PURPOSE
//  Clocked, parametrised GPR/PC/FLAGS state store for the tiny86 step circuit.
//  Loads initial architectural state through a valid/ready stream, then commits one instruction step per handshake.
//  Each step carries NWR prioritised register writes plus next PC/FLAGS.
//  Feeds decode/ALU through NRD combinational read ports; exposes full state for end-of-trace comparison.
// PARAMETERS
//  WIDTH  32  register/PC/FLAGS width in bits
//  NREGS  8   number of GPRs (index order EAX,ECX,EDX,EBX,ESP,EBP,ESI,EDI per REG_* defines)
//  NWR    2   write ports per step; port 0 has highest priority
//  NRD    3   combinational read ports
//  CNT_W  32  step counter width
//  (derived localparams: SEL_W=$clog2(NREGS), LD_W=$clog2(NREGS+2))
// PORTS
//  clk         in   1             clock, all state updates on rising edge
//  rst         in   1             asynchronous, active-high reset
//  init_valid  in   1             initial-state word valid
//  init_ready  out  1             high only in LOAD
//  init_data   in   WIDTH         initial-state word
//  step_valid  in   1             step commit request
//  step_ready  out  1             high only in RUN
//  wr_en       in   NWR           per-port write enable
//  wr_sel      in   NWR*SEL_W     per-port GPR index, port i at [i*SEL_W +: SEL_W]
//  wr_data     in   NWR*WIDTH     per-port data
//  next_pc     in   WIDTH         PC after step
//  next_flags  in   WIDTH         FLAGS after step
//  halt        in   1             end of trace request
//  rd_sel      in   NRD*SEL_W     read indices
//  rd_data     out  NRD*WIDTH     read data, current committed state
//  pc, flags   out  WIDTH each    committed PC / FLAGS
//  gpr_flat    out  NREGS*WIDTH   all GPRs, reg i at [i*WIDTH +: WIDTH]
//  step_count  out  CNT_W         accepted steps, saturating
//  loaded      out  1             high in RUN and DONE
//  done        out  1             high in DONE
// BEHAVIOUR
//  Reset: all GPRs, pc, flags, step_count, load index = 0; state=LOAD; init_ready=1; step_ready=loaded=done=0.
//    Reset mid-load or mid-run discards all state identically.
//  FSM: LOAD -> RUN -> DONE; only reset leaves DONE.
//  LOAD: word accepted on init_valid&&init_ready; load index 0..NREGS-1 writes GPR[idx],
//    NREGS writes pc, NREGS+1 writes flags; state=RUN on the edge accepting flags.
//    step_valid/halt are ignored in LOAD.
//  RUN: step accepted on step_valid&&step_ready; at that edge pc<=next_pc, flags<=next_flags, step_count+=1.
//    step_count saturates at all-ones.
//    For each GPR r: new value = wr_data of lowest i with wr_en[i] && wr_sel_i==r; else unchanged.
//    wr_en, next_pc, next_flags are ignored unless the step is accepted.
//    wr_sel >= NREGS: that write is dropped.
//  halt in RUN: state=DONE next edge; a step accepted in the same cycle still commits.
//    halt in LOAD is ignored.
//  DONE: step_ready=0, init_ready=0; all state frozen.
//  Reads: rd_data is combinational from committed state, no write bypass.
//    A write is visible on the cycle after acceptance. rd_sel >= NREGS returns 0.
//  init_valid in RUN/DONE: ignored, no state change.
// STRUCTURE
//  include/defines.v: REG_* indices, RFS_LOAD/RFS_RUN/RFS_DONE state encodings (2 bits).
//  include/funcs.v: reuse one_hot8 for NREGS==8; generic one-hot decode loop otherwise.
//  Sub-module regfile_wr_prio: combinational NWR-port priority select for one register
//    (inputs wr_en, per-port hit, wr_data; outputs we, wdata). Instantiated NREGS times via generate.
// TESTING
//  Load 1..10 (NREGS=8), then idle -> GPR[i]=i+1, pc=9, flags=10, loaded=1 on edge after 10th word.
//  Step, wr_en=2'b11, both sel=EAX, data0=AAAA_AAAA, data1=5555_5555 -> EAX=AAAA_AAAA; step_count=1.
//  Step writes ECX=0000_0042 while rd_sel=ECX -> rd_data shows old ECX that cycle, 42 next cycle.
//  step_valid=1 with step_ready=0 (during LOAD) -> no GPR/pc/step_count change.
//  halt and step in same cycle -> step commits, done=1, later steps ignored, state frozen.
//  rst mid-LOAD after 3 words, then full reload -> values from first attempt absent.
//  CNT_W=2, 5 steps -> step_count = 3 (saturated).

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types for the tiny86 architectural state store: FSM states and GPR indices.
package regfile_seq_pkg;

  typedef enum logic [1:0] {
    RFS_LOAD = 2'd0,
    RFS_RUN  = 2'd1,
    RFS_DONE = 2'd2
  } rfs_state_e;

  localparam int REG_EAX = 0;
  localparam int REG_ECX = 1;
  localparam int REG_EDX = 2;
  localparam int REG_EBX = 3;
  localparam int REG_ESP = 4;
  localparam int REG_EBP = 5;
  localparam int REG_ESI = 6;
  localparam int REG_EDI = 7;

endpackage

// File: rtl/regfile_wr_prio.sv
// Per-register write-port priority select: the lowest enabled port that targets
// this register supplies the data.
module regfile_wr_prio
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NWR   = 2
) (
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR-1:0]       hit,
  input  logic [NWR*WIDTH-1:0] wr_data,
  output logic                 we,
  output logic [WIDTH-1:0]     wdata
);

  // Walk from the weakest port up so port 0 overwrites everything else.
  always_comb begin
    we    = 1'b0;
    wdata = '0;
    for (int i = NWR - 1; i >= 0; i--) begin
      wdata = (wr_en[i] && hit[i]) ? wr_data[i*WIDTH +: WIDTH] : wdata;
      we    = we | (wr_en[i] & hit[i]);
    end
  end

endmodule

// File: rtl/regfile_seq.sv
// GPR/PC/FLAGS state store: streams in initial state, then commits one
// instruction step per handshake until halted.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  parameter int NWR   = 2,
  parameter int NRD   = 3,
  parameter int CNT_W = 32,
  localparam int SEL_W = $clog2(NREGS),
  localparam int LD_W  = $clog2(NREGS + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_valid,
  output logic                   init_ready,
  input  logic [WIDTH-1:0]       init_data,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*SEL_W-1:0]   wr_sel,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  input  logic [WIDTH-1:0]       next_pc,
  input  logic [WIDTH-1:0]       next_flags,
  input  logic                   halt,
  input  logic [NRD*SEL_W-1:0]   rd_sel,
  output logic [NRD*WIDTH-1:0]   rd_data,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       flags,
  output logic [NREGS*WIDTH-1:0] gpr_flat,
  output logic [CNT_W-1:0]       step_count,
  output logic                   loaded,
  output logic                   done
);

  rfs_state_e       state_r, state_nx_s;
  logic [LD_W-1:0]  load_idx_r;
  logic [WIDTH-1:0] gpr_r [NREGS];
  logic [WIDTH-1:0] pc_r, flags_r;
  logic [CNT_W-1:0] cnt_r;
  logic             init_ready_r, step_ready_r, loaded_r, done_r;
  logic             init_acc_s, step_acc_s;
  logic [NREGS-1:0] we_s;
  logic [WIDTH-1:0] wdata_s [NREGS];

  assign init_acc_s = init_valid && (state_r == RFS_LOAD);
  assign step_acc_s = step_valid && (state_r == RFS_RUN);

  // One priority selector per GPR; out-of-range selects match nothing and drop.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    logic [NWR-1:0] hit_s;
    for (genvar i = 0; i < NWR; i++) begin : g_hit
      assign hit_s[i] = (wr_sel[i*SEL_W +: SEL_W] == SEL_W'(r));
    end
    regfile_wr_prio #(.WIDTH(WIDTH), .NWR(NWR)) u_prio (
      .wr_en   (wr_en),
      .hit     (hit_s),
      .wr_data (wr_data),
      .we      (we_s[r]),
      .wdata   (wdata_s[r])
    );
    assign gpr_flat[r*WIDTH +: WIDTH] = gpr_r[r];
  end

  // Next-state logic; the flags word is the last one of the load stream.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      RFS_LOAD: begin
        if (init_acc_s && (load_idx_r == LD_W'(NREGS + 1))) state_nx_s = RFS_RUN;
        else                                                 state_nx_s = RFS_LOAD;
      end
      RFS_RUN: begin
        if (halt) state_nx_s = RFS_DONE;
        else      state_nx_s = RFS_RUN;
      end
      RFS_DONE: state_nx_s = RFS_DONE;
      default:  state_nx_s = RFS_LOAD;
    endcase
  end

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= RFS_LOAD;
      init_ready_r <= 1'b1;
      step_ready_r <= 1'b0;
      loaded_r     <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      init_ready_r <= (state_nx_s == RFS_LOAD);
      step_ready_r <= (state_nx_s == RFS_RUN);
      loaded_r     <= (state_nx_s == RFS_RUN) || (state_nx_s == RFS_DONE);
      done_r       <= (state_nx_s == RFS_DONE);
    end
  end

  // Load word index and GPR array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx_r <= '0;
      for (int r = 0; r < NREGS; r++) gpr_r[r] <= '0;
    end else begin
      if (init_acc_s) load_idx_r <= load_idx_r + LD_W'(1);
      for (int r = 0; r < NREGS; r++) begin
        if (init_acc_s && (load_idx_r == LD_W'(r))) gpr_r[r] <= init_data;
        else if (step_acc_s && we_s[r])             gpr_r[r] <= wdata_s[r];
      end
    end
  end

  // PC, FLAGS and saturating step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r    <= '0;
      flags_r <= '0;
      cnt_r   <= '0;
    end else begin
      if (init_acc_s && (load_idx_r == LD_W'(NREGS)))          pc_r    <= init_data;
      else if (step_acc_s)                                     pc_r    <= next_pc;
      if (init_acc_s && (load_idx_r == LD_W'(NREGS + 1)))      flags_r <= init_data;
      else if (step_acc_s)                                     flags_r <= next_flags;
      if (step_acc_s && (cnt_r != {CNT_W{1'b1}}))              cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Read ports see committed state only; no bypass of the step being accepted.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NRD; j++) begin
      if ({1'b0, rd_sel[j*SEL_W +: SEL_W]} < (SEL_W + 1)'(NREGS))
        rd_data[j*WIDTH +: WIDTH] = gpr_r[rd_sel[j*SEL_W +: SEL_W]];
      else
        rd_data[j*WIDTH +: WIDTH] = '0;
    end
  end

  assign init_ready = init_ready_r;
  assign step_ready = step_ready_r;
  assign loaded     = loaded_r;
  assign done       = done_r;
  assign pc         = pc_r;
  assign flags      = flags_r;
  assign step_count = cnt_r;

endmodule
